// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller states and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_adder1bit.sv
// Team 1-bit full-adder cell; the only arithmetic element of the serial adder.
module adder1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell processes one bit per clock, LSB first,
// giving a WIDTH-cycle latency from acceptance to the done pulse.
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] TERM = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_resNext;

    assign w_accept = (r_state != RUN) && start;
    assign w_last   = (r_state == RUN) && (r_cnt == TERM);
    assign sum      = r_sum;
    assign cout     = r_cout;

    adder1bit u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_co)
    );

    // Each new sum bit enters at the MSB so that after WIDTH shifts bit i sits at position i.
    generate
        if (WIDTH > 1) begin : g_wide
            assign w_resNext = {w_s, r_res[WIDTH-1:1]};
        end else begin : g_narrow
            assign w_resNext = w_s;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // Visible result only changes on the final RUN edge, so new operands cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_co;
            r_res   <= w_resNext;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_resNext;
                r_cout <= w_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq (WIDTH=8): directed scenarios plus
// an arithmetic reference model compared on every cycle.
module tb_serial_adder_seq;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks   = 0;
    int failures = 0;
    int cycNum   = 0;

    int               mLeft      = 0;
    logic             mDone      = 1'b0;
    logic [WIDTH-1:0] mSum       = '0;
    logic             mCout      = 1'b0;
    logic [WIDTH:0]   mPend      = '0;
    int               mAcceptCyc = 0;

    serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycNum <= cycNum + 1;

    // Reference: accepted operands give (a+b+cin) exactly WIDTH edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mLeft <= 0;
            mDone <= 1'b0;
            mSum  <= '0;
            mCout <= 1'b0;
        end else begin
            mDone <= 1'b0;
            if (mLeft > 0) begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mDone <= 1'b1;
                    mSum  <= mPend[WIDTH-1:0];
                    mCout <= mPend[WIDTH];
                end
            end else if (start) begin
                mPend      <= (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
                mLeft      <= WIDTH;
                mAcceptCyc <= cycNum + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("busy", 64'(busy), 64'(mLeft > 0));
        checkOutput("done", 64'(done), 64'(mDone));
        checkOutput("sum", 64'(sum), 64'(mSum));
        checkOutput("cout", 64'(cout), 64'(mCout));
        if (done === 1'b1 && rst_n)
            checkOutput("latency", 64'(cycNum - mAcceptCyc), 64'(WIDTH));
    end

    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic c);
        @(posedge clk);
        #1;
        start = s;
        a     = av;
        b     = bv;
        cin   = c;
    endtask

    task automatic waitDone(output int cyc);
        bit seen = 0;
        cyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                cyc  = cycNum;
            end
        end
        if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic countDones(input int n, output int cnt,
                              output logic [WIDTH-1:0] s, output logic c);
        cnt = 0;
        s   = '0;
        c   = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cnt++;
                s = sum;
                c = cout;
            end
        end
    endtask

    task automatic runOp(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic c, input logic [WIDTH-1:0] expSum, input logic expCout);
        int cyc;
        applyStimulus(1'b1, av, bv, c);
        applyStimulus(1'b0, ~av, ~bv, ~c);
        waitDone(cyc);
        checkOutput({name, "_sum"}, 64'(sum), 64'(expSum));
        checkOutput({name, "_cout"}, 64'(cout), 64'(expCout));
        checkOutput({name, "_model"}, 64'({mCout, mSum}), 64'({expCout, expSum}));
    endtask

    initial begin
        int               d1;
        int               d2;
        int               cnt;
        logic [WIDTH-1:0] s;
        logic             c;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        runOp("a5_plus_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        runOp("zero_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Start re-pulsed three edges after acceptance must be ignored.
        applyStimulus(1'b1, 8'h33, 8'h44, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h11, 8'h11, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        countDones(20, cnt, s, c);
        checkOutput("ignore_done_count", 64'(cnt), 64'd1);
        checkOutput("ignore_sum", 64'(s), 64'h77);
        checkOutput("ignore_cout", 64'(c), 64'd0);

        // Start held through DONE chains a second run with period WIDTH+1.
        applyStimulus(1'b1, 8'h01, 8'h02, 1'b0);
        applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
        waitDone(d1);
        checkOutput("b2b_first_sum", 64'(sum), 64'h03);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        waitDone(d2);
        checkOutput("b2b_period", 64'(d2 - d1), 64'd9);
        checkOutput("b2b_sum", 64'(sum), 64'h30);
        checkOutput("b2b_cout", 64'(cout), 64'd0);

        // Reset four cycles into a run clears outputs at once and suppresses done.
        applyStimulus(1'b1, 8'h12, 8'h34, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_sum", 64'(sum), 64'd0);
        checkOutput("abort_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countDones(12, cnt, s, c);
        checkOutput("abort_no_done", 64'(cnt), 64'd0);

        // Start presented on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        a     = 8'h7F;
        b     = 8'h01;
        cin   = 1'b0;
        applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1);
        waitDone(d1);
        checkOutput("post_reset_sum", 64'(sum), 64'h80);
        checkOutput("post_reset_cout", 64'(cout), 64'd0);

        // Random operands, disturbed during RUN; the per-cycle model checks each one.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            applyStimulus(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            waitDone(d1);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
